dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data accesses; the CPU is the initiator.
- Accepts one load/store request at a time over a valid/ready handshake.
- Holds a local 16-bit word array and returns read data after a programmable number of wait states.
- Produces a stall indication so the pipeline can freeze while an access is outstanding.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_lane_merge.sv | 33 +++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared constants, state codes, request record and error classification for dmem_responder.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;

    typedef struct packed {
        logic              we;
        logic              is_byte;
        logic [15:0]       addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Range violations take precedence over alignment so a single code is reported.
    function automatic logic [1:0] classify_err(input logic out_of_range, input logic misaligned);
        logic [1:0] code;
        if (out_of_range) begin
            code = ERR_RANGE;
        end else if (misaligned) begin
            code = ERR_ALIGN;
        end else begin
            code = ERR_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM-stage initiator (master) and dmem_responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [15:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );

endinterface

// File: rtl/dmem_lane_merge.sv
// Byte-lane extract on load and read-modify-write merge on store; built only with DMEM_BYTE_EN.
`ifdef DMEM_BYTE_EN
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] word_in,
    input  logic [DATA_W-1:0] wdata,
    input  logic              lane,
    input  logic              is_byte,
    output logic [DATA_W-1:0] merged,
    output logic [DATA_W-1:0] rdata
);

    // Select the addressed lane for both directions; word accesses pass through.
    always_comb begin
        merged = word_in;
        rdata  = word_in;
        if (is_byte) begin
            if (lane) begin
                merged = {wdata[BYTE_W-1:0], word_in[BYTE_W-1:0]};
                rdata  = {8'h00, word_in[DATA_W-1:BYTE_W]};
            end else begin
                merged = {word_in[DATA_W-1:BYTE_W], wdata[BYTE_W-1:0]};
                rdata  = {8'h00, word_in[BYTE_W-1:0]};
            end
        end else begin
            merged = wdata;
            rdata  = word_in;
        end
    end

endmodule
`endif

// File: rtl/dmem_responder.sv
// MEM-stage data responder: one access at a time, WAIT_CYCLES wait states, 16-bit word array.
// Optional byte access is enabled by defining DMEM_BYTE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [3:0]        cnt_r;
    req_t              req_r;
    req_t              in_req_s;
    req_t              cur_s;
    logic              accept_s;
    logic              enter_resp_s;
    logic              out_of_range_s;
    logic              misaligned_s;
    logic [1:0]        err_code_s;
    logic [ADDR_W-1:0] idx_s;
    logic [DATA_W-1:0] word_old_s;
    logic [DATA_W-1:0] wr_word_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              mem_we_s;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    assign accept_s = bus.req_valid & (state_r == ST_IDLE);

    assign in_req_s.we      = bus.req_we;
`ifdef DMEM_BYTE_EN
    assign in_req_s.is_byte = bus.req_byte;
`else
    logic unused_req_byte_s;
    assign unused_req_byte_s = bus.req_byte;
    assign in_req_s.is_byte  = 1'b0;
`endif
    assign in_req_s.addr    = bus.req_addr;
    assign in_req_s.wdata   = bus.req_wdata;

    // With zero wait states the store lands on the acceptance edge, so the live request is used.
    assign cur_s = (state_r == ST_IDLE) ? in_req_s : req_r;

    assign out_of_range_s = ((cur_s.addr >> (ADDR_W + 1)) != 16'd0);
    assign misaligned_s   = cur_s.addr[0] & ~cur_s.is_byte;
    assign err_code_s     = classify_err(out_of_range_s, misaligned_s);
    assign idx_s          = cur_s.addr[ADDR_W:1];
    assign word_old_s     = mem_r[idx_s];

`ifdef DMEM_BYTE_EN
    dmem_lane_merge u_lane_merge (
        .word_in (word_old_s),
        .wdata   (cur_s.wdata),
        .lane    (cur_s.addr[0]),
        .is_byte (cur_s.is_byte),
        .merged  (wr_word_s),
        .rdata   (rd_data_s)
    );
`else
    assign wr_word_s = cur_s.wdata;
    assign rd_data_s = word_old_s;
`endif

    // Next-state decode for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (WAIT_LOAD == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    assign mem_we_s     = rst & enter_resp_s & cur_s.we & (err_code_s == ERR_NONE);

    // Sequencer, wait counter, request latch and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            req_r        <= '0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 16'h0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                req_r <= in_req_s;
                cnt_r <= WAIT_LOAD;
            end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            resp_valid_r <= (state_r == ST_RESP);
            if (state_r == ST_RESP) begin
                resp_err_r   <= (err_code_s != ERR_NONE);
                resp_rdata_r <= ((err_code_s != ERR_NONE) || req_r.we) ? 16'h0000 : rd_data_s;
            end else begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 16'h0000;
            end
        end
    end

    // Word array; contents survive reset and erroring stores never reach it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.stall      = bus.req_valid & ~resp_valid_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request (z selects the zero-wait instance) and measure edges until resp_valid.
    task automatic xact(input bit z, input logic we, input logic bt, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output logic er,
                        output int lat);
        if (z) begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_byte = bt;
            bus0.req_addr = addr; bus0.req_wdata = wd;
        end else begin
            bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = bt;
            bus.req_addr = addr; bus.req_wdata = wd;
        end
        step();
        bus.req_valid  = 1'b0;
        bus0.req_valid = 1'b0;
        lat = 0;
        rd  = 16'hxxxx;
        er  = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (z ? bus0.resp_valid : bus.resp_valid) begin
                lat = k;
                rd  = z ? bus0.resp_rdata : bus.resp_rdata;
                er  = z ? bus0.resp_err : bus.resp_err;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;

        bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_byte  = 1'b0;
        bus.req_addr   = 16'h0000; bus.req_wdata = 16'h0000;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_byte = 1'b0;
        bus0.req_addr  = 16'h0000; bus0.req_wdata = 16'h0000;

        // Reset
        repeat (3) step();
        check("rst_ready", {15'd0, bus.req_ready}, 16'h0001);
        check("rst_valid", {15'd0, bus.resp_valid}, 16'h0000);
        check("rst_rdata", bus.resp_rdata, 16'h0000);
        check("rst_err", {15'd0, bus.resp_err}, 16'h0000);
        check("rst_stall", {15'd0, bus.stall}, 16'h0000);
        rst = 1'b1;
        step();

        // Word store then load
        xact(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, er, lat);
        check("st_lat", 16'(lat), 16'd3);
        check("st_err", {15'd0, er}, 16'h0000);
        check("st_rdata", rd, 16'h0000);
        xact(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat);
        check("ld_lat", 16'(lat), 16'd3);
        check("ld_rdata", rd, 16'hBEEF);
        check("ld_err", {15'd0, er}, 16'h0000);

        // Errors: misaligned load and out-of-range store
        xact(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, rd, er, lat);
        xact(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, rd, er, lat);
        check("mis_err", {15'd0, er}, 16'h0001);
        check("mis_rdata", rd, 16'h0000);
        xact(1'b0, 1'b1, 1'b0, 16'h0400, 16'h2222, rd, er, lat);
        check("oor_err", {15'd0, er}, 16'h0001);
        xact(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
        check("oor_keep", rd, 16'h1111);
        check("oor_keep_err", {15'd0, er}, 16'h0000);

        // Byte lanes
        xact(1'b0, 1'b1, 1'b0, 16'h0020, 16'h1234, rd, er, lat);
`ifdef DMEM_BYTE_EN
        xact(1'b0, 1'b1, 1'b1, 16'h0021, 16'hCDAB, rd, er, lat);
        check("bst_err", {15'd0, er}, 16'h0000);
        xact(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
        check("bmerge", rd, 16'hAB34);
        xact(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, rd, er, lat);
        check("bld_lo", rd, 16'h0034);
        xact(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000, rd, er, lat);
        check("bld_hi", rd, 16'h00AB);
`else
        xact(1'b0, 1'b1, 1'b1, 16'h0021, 16'hCDAB, rd, er, lat);
        check("nobyte_err", {15'd0, er}, 16'h0001);
        xact(1'b0, 1'b1, 1'b1, 16'h0022, 16'h5678, rd, er, lat);
        check("nobyte_wst_err", {15'd0, er}, 16'h0000);
        xact(1'b0, 1'b0, 1'b1, 16'h0022, 16'h0000, rd, er, lat);
        check("nobyte_word", rd, 16'h5678);
        xact(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, rd, er, lat);
        check("nobyte_keep", rd, 16'h1234);
`endif

        // Handshake: second request held during the first access
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_byte = 1'b0;
        bus.req_addr = 16'h0010;
        step();
        bus.req_addr = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            check("hs_ready", {15'd0, bus.req_ready}, 16'h0000);
            check("hs_stall", {15'd0, bus.stall}, 16'h0001);
            check("hs_novalid", {15'd0, bus.resp_valid}, 16'h0000);
            step();
        end
        check("hs_resp1", {15'd0, bus.resp_valid}, 16'h0001);
        check("hs_rdata1", bus.resp_rdata, 16'hBEEF);
        check("hs_stall_resp", {15'd0, bus.stall}, 16'h0000);
        check("hs_ready_resp", {15'd0, bus.req_ready}, 16'h0001);
        step();
        bus.req_valid = 1'b0;
        check("hs_accept2", {15'd0, bus.req_ready}, 16'h0000);
        lat = 0;
        rd  = 16'hxxxx;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (bus.resp_valid) begin
                lat = k;
                rd  = bus.resp_rdata;
                break;
            end
        end
        check("hs_lat2", 16'(lat), 16'd3);
        check("hs_rdata2", rd, 16'h1111);

        // Reset during WAIT drops a pending store
        xact(1'b0, 1'b1, 1'b0, 16'h0030, 16'h7777, rd, er, lat);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_byte = 1'b0;
        bus.req_addr = 16'h0030; bus.req_wdata = 16'h5555;
        step();
        bus.req_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mrst_idle", {15'd0, bus.req_ready}, 16'h0001);
        check("mrst_novalid", {15'd0, bus.resp_valid}, 16'h0000);
        er = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.resp_valid) er = 1'b1;
        end
        check("mrst_quiet", {15'd0, er}, 16'h0000);
        xact(1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, rd, er, lat);
        check("mrst_old", rd, 16'h7777);

        // Zero wait states: back-to-back loads
        xact(1'b1, 1'b1, 1'b0, 16'h0002, 16'hA5A5, rd, er, lat);
        check("w0_st_lat", 16'(lat), 16'd1);
        xact(1'b1, 1'b1, 1'b0, 16'h0004, 16'h5A5A, rd, er, lat);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_byte = 1'b0;
        bus0.req_addr = 16'h0002;
        step();
        bus0.req_addr = 16'h0004;
        check("w0_busy", {15'd0, bus0.req_ready}, 16'h0000);
        step();
        check("w0_resp1", {15'd0, bus0.resp_valid}, 16'h0001);
        check("w0_rdata1", bus0.resp_rdata, 16'hA5A5);
        step();
        bus0.req_valid = 1'b0;
        check("w0_gap", {15'd0, bus0.resp_valid}, 16'h0000);
        step();
        check("w0_resp2", {15'd0, bus0.resp_valid}, 16'h0001);
        check("w0_rdata2", bus0.resp_rdata, 16'h5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
